// File: rtl/arbitro_balance_cajeros.sv
// arbitro_balance_cajeros: round-robin arbiter sharing one account balance among N_TERM ATM terminals
// Ports: clock/reset (sync, active-high); CARGAR_BALANCE/BALANCE_INICIAL load the balance in IDLE;
// REQ/TIPO_TRANS/MONTO_BUS per-terminal requests (1 = withdrawal); GRANT one-hot, ACK and
// FONDOS_INSUFICIENTES per-terminal pulses; BALANCE_ACTUALIZADO/BALANCE_STB balance and change pulse;
// ENTREGAR_DINERO accepted-withdrawal pulse; OCUPADO high outside IDLE.
// Build option: define CAJERO_PRIORIDAD_FIJA_EN for fixed priority (lowest index wins, no RR pointer).
module arbitro_balance_cajeros #(
  parameter int N_TERM         = 4,
  parameter int ANCHO_MONTO    = 32,
  parameter int ANCHO_BAL      = 64,
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          CARGAR_BALANCE,
  input  logic [ANCHO_BAL-1:0]          BALANCE_INICIAL,
  input  logic [N_TERM-1:0]             REQ,
  input  logic [N_TERM-1:0]             TIPO_TRANS,
  input  logic [N_TERM*ANCHO_MONTO-1:0] MONTO_BUS,
  output logic [N_TERM-1:0]             GRANT,
  output logic [N_TERM-1:0]             ACK,
  output logic [N_TERM-1:0]             FONDOS_INSUFICIENTES,
  output logic [ANCHO_BAL-1:0]          BALANCE_ACTUALIZADO,
  output logic                          BALANCE_STB,
  output logic                          ENTREGAR_DINERO,
  output logic                          OCUPADO
);
  localparam int GW = $clog2(N_TERM);
  localparam int TW = $clog2(TIMEOUT_CICLOS + 1);
  typedef enum logic [2:0] {IDLE, CAPTURA, EJECUTA, RESPUESTA, LIBERA} estado_t;
  estado_t estado;
  logic [N_TERM-1:0] rot;
  logic [GW:0] off;
  logic [GW-1:0] win;
  logic [TW-1:0] cnt;
  logic [ANCHO_MONTO-1:0] monto, monto_sel;
  logic retiro, ok, insuf, cambio, libera, falta;
  logic [ANCHO_BAL-1:0] monto_ext, bal_nuevo;
  logic [ANCHO_BAL:0] suma;
  // rot holds the requests rotated so bit 0 is the terminal the pointer favours
  always_comb begin
    off = '0;
    for (int k = N_TERM - 1; k >= 0; k--) off = rot[k] ? (GW+1)'(k) : off;
  end
`ifdef CAJERO_PRIORIDAD_FIJA_EN
  assign rot = REQ;
  assign win = GW'(off);
`else
  logic [GW-1:0] rr, gsel;
  logic [GW:0] suma_rr;
  assign rot = N_TERM'({REQ, REQ} >> rr);
  assign suma_rr = {1'b0, rr} + off;
  assign win = GW'(suma_rr >= (GW+1)'(N_TERM) ? suma_rr - (GW+1)'(N_TERM) : suma_rr);
  always_ff @(posedge clock) begin
    if (reset) begin
      rr <= '0;
      gsel <= '0;
    end else if (estado == IDLE && !CARGAR_BALANCE && |REQ) begin
      gsel <= win;
    end else if (estado == LIBERA && libera) begin
      rr <= gsel == GW'(N_TERM - 1) ? '0 : gsel + 1'b1;
    end
  end
`endif
  always_comb begin
    monto_sel = '0;
    for (int i = 0; i < N_TERM; i++) monto_sel = GRANT[i] ? MONTO_BUS[i*ANCHO_MONTO +: ANCHO_MONTO] : monto_sel;
  end
  always_comb begin
    monto_ext = ANCHO_BAL'(monto);
    suma = {1'b0, BALANCE_ACTUALIZADO} + {1'b0, monto_ext};
    falta = monto_ext > BALANCE_ACTUALIZADO;
    bal_nuevo = retiro ? (falta ? BALANCE_ACTUALIZADO : BALANCE_ACTUALIZADO - monto_ext)
                       : (suma[ANCHO_BAL] ? '1 : suma[ANCHO_BAL-1:0]);
  end
  // release when the granted terminal drops its request, or after TIMEOUT_CICLOS cycles in LIBERA
  assign libera = !(|(REQ & GRANT)) || cnt == TW'(TIMEOUT_CICLOS - 1);
  assign OCUPADO = estado != IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= IDLE;
      GRANT <= '0;
      ACK <= '0;
      FONDOS_INSUFICIENTES <= '0;
      BALANCE_ACTUALIZADO <= '0;
      BALANCE_STB <= 1'b0;
      ENTREGAR_DINERO <= 1'b0;
      cnt <= '0;
      monto <= '0;
      retiro <= 1'b0;
      ok <= 1'b0;
      insuf <= 1'b0;
      cambio <= 1'b0;
    end else begin
      ACK <= '0;
      FONDOS_INSUFICIENTES <= '0;
      BALANCE_STB <= 1'b0;
      ENTREGAR_DINERO <= 1'b0;
      case (estado)
        IDLE: begin
          if (CARGAR_BALANCE) begin
            BALANCE_ACTUALIZADO <= BALANCE_INICIAL;
            BALANCE_STB <= 1'b1;
          end else if (|REQ) begin
            GRANT <= N_TERM'(1) << win;
            estado <= CAPTURA;
          end
        end
        CAPTURA: begin
          retiro <= |(TIPO_TRANS & GRANT);
          monto <= monto_sel;
          estado <= EJECUTA;
        end
        EJECUTA: begin
          BALANCE_ACTUALIZADO <= bal_nuevo;
          ok <= retiro && !falta;
          insuf <= retiro && falta;
          cambio <= bal_nuevo != BALANCE_ACTUALIZADO;
          estado <= RESPUESTA;
        end
        RESPUESTA: begin
          ACK <= GRANT;
          FONDOS_INSUFICIENTES <= insuf ? GRANT : '0;
          ENTREGAR_DINERO <= ok;
          BALANCE_STB <= cambio;
          cnt <= '0;
          estado <= LIBERA;
        end
        LIBERA: begin
          if (libera) begin
            GRANT <= '0;
            estado <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: estado <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arbitro_balance_cajeros.sv
// tb_arbitro_balance_cajeros: table, hand-written and random checks against a transaction-level model
module tb_arbitro_balance_cajeros;
  localparam int N = 4;
  localparam int AM = 32;
  localparam int AB = 64;
  localparam logic [AB-1:0] MAXB = {AB{1'b1}};
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic CARGAR_BALANCE = 1'b0;
  logic [AB-1:0] BALANCE_INICIAL = '0;
  logic [N-1:0] REQ = '0;
  logic [N-1:0] TIPO_TRANS = '0;
  logic [N*AM-1:0] MONTO_BUS = '0;
  logic [N-1:0] GRANT, ACK, FONDOS_INSUFICIENTES;
  logic [AB-1:0] BALANCE_ACTUALIZADO;
  logic BALANCE_STB, ENTREGAR_DINERO, OCUPADO;
  int checks = 0;
  int errors = 0;
  logic [AB-1:0] bal_m = '0;
  int rr_m = 0;
  always #5 clock = ~clock;
  arbitro_balance_cajeros dut (
    .clock(clock), .reset(reset), .CARGAR_BALANCE(CARGAR_BALANCE), .BALANCE_INICIAL(BALANCE_INICIAL),
    .REQ(REQ), .TIPO_TRANS(TIPO_TRANS), .MONTO_BUS(MONTO_BUS), .GRANT(GRANT), .ACK(ACK),
    .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES), .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO),
    .BALANCE_STB(BALANCE_STB), .ENTREGAR_DINERO(ENTREGAR_DINERO), .OCUPADO(OCUPADO)
  );
  typedef struct {
    bit cargar;
    logic [AB-1:0] carga;
    int term;
    bit retiro;
    logic [AM-1:0] monto;
    logic [AB-1:0] e_bal;
    bit e_fi;
    bit e_ent;
    bit e_stb;
  } vec_t;
  vec_t tabla [8];
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string nm, input logic [AB-1:0] act, input logic [AB-1:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, req_v);
    end
  endtask
  function automatic logic [N-1:0] oh(input int g);
    return N'(1) << g;
  endfunction
  // winner: first requester at or after the pointer, wrapping; lowest index in the fixed build
  function automatic int winner(input logic [N-1:0] r);
`ifdef CAJERO_PRIORIDAD_FIJA_EN
    for (int k = 0; k < N; k++) if (r[k]) return k;
`else
    for (int k = 0; k < N; k++) if (r[(rr_m + k) % N]) return (rr_m + k) % N;
`endif
    return 0;
  endfunction
  task automatic chk_reset_outs(input string nm);
    chk({nm, "_grant"}, GRANT, '0);
    chk({nm, "_ack"}, ACK, '0);
    chk({nm, "_fi"}, FONDOS_INSUFICIENTES, '0);
    chk({nm, "_bal"}, BALANCE_ACTUALIZADO, '0);
    chk({nm, "_stb"}, BALANCE_STB, '0);
    chk({nm, "_ent"}, ENTREGAR_DINERO, '0);
    chk({nm, "_ocupado"}, OCUPADO, '0);
  endtask
  task automatic do_load(input logic [AB-1:0] v);
    CARGAR_BALANCE = 1'b1;
    BALANCE_INICIAL = v;
    tick();
    chk("carga_stb", BALANCE_STB, 1);
    chk("carga_bal", BALANCE_ACTUALIZADO, v);
    chk("carga_ocupado", OCUPADO, 0);
    CARGAR_BALANCE = 1'b0;
    tick();
    chk("carga_stb_fin", BALANCE_STB, 0);
    bal_m = v;
  endtask
  // one full transaction from IDLE; checks grant, ACK latency and release, returns response
  task automatic do_txn(input logic [N-1:0] r, input logic [N-1:0] t, input logic [N*AM-1:0] mb,
                        output int g, output logic [N-1:0] fi, output logic ent, output logic stb,
                        output logic [AB-1:0] b);
    int n;
    REQ = r;
    TIPO_TRANS = t;
    MONTO_BUS = mb;
    g = winner(r);
    tick();
    chk("grant", GRANT, oh(g));
    chk("ocupado", OCUPADO, 1);
    n = 1;
    while (ACK == '0 && n < 10) begin
      tick();
      n++;
    end
    chk("latencia", n, 4);
    chk("ack", ACK, oh(g));
    fi = FONDOS_INSUFICIENTES;
    ent = ENTREGAR_DINERO;
    stb = BALANCE_STB;
    b = BALANCE_ACTUALIZADO;
    REQ = '0;
    rr_m = (g + 1) % N;
    n = 0;
    while (OCUPADO && n < 40) begin
      tick();
      n++;
    end
    chk("libera_ocupado", OCUPADO, 0);
    chk("libera_grant", GRANT, '0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [N-1:0] r, t, fi;
    logic ent, stb, ackseen, w, e_fi, e_ent;
    logic [AB-1:0] b, nb;
    logic [N*AM-1:0] mb;
    logic [AM-1:0] m;
    logic [AB:0] s;
    int g, n, hi, eg;
    tabla[0] = '{1'b1, 64'd1000, 1, 1'b1, 32'd300, 64'd700, 1'b0, 1'b1, 1'b1};
    tabla[1] = '{1'b0, 64'd0, 2, 1'b1, 32'd701, 64'd700, 1'b1, 1'b0, 1'b0};
    tabla[2] = '{1'b0, 64'd0, 3, 1'b0, 32'd0, 64'd700, 1'b0, 1'b0, 1'b0};
    tabla[3] = '{1'b0, 64'd0, 0, 1'b1, 32'd700, 64'd0, 1'b0, 1'b1, 1'b1};
    tabla[4] = '{1'b0, 64'd0, 2, 1'b1, 32'd0, 64'd0, 1'b0, 1'b1, 1'b0};
    tabla[5] = '{1'b1, MAXB - 64'd4, 1, 1'b0, 32'd10, MAXB, 1'b0, 1'b0, 1'b1};
    tabla[6] = '{1'b0, 64'd0, 0, 1'b0, 32'd5, MAXB, 1'b0, 1'b0, 1'b0};
    tabla[7] = '{1'b1, 64'd50, 3, 1'b0, 32'hFFFF_FFFF, 64'd4294967345, 1'b0, 1'b0, 1'b1};
    repeat (3) tick();
    chk_reset_outs("reset");
    reset = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (tabla[i].cargar) do_load(tabla[i].carga);
      r = oh(tabla[i].term);
      t = N'($urandom);
      t[tabla[i].term] = tabla[i].retiro;
      for (int k = 0; k < N; k++) mb[k*AM +: AM] = $urandom;
      mb[tabla[i].term*AM +: AM] = tabla[i].monto;
      do_txn(r, t, mb, g, fi, ent, stb, b);
      chk("tab_bal", b, tabla[i].e_bal);
      chk("tab_fi", fi, tabla[i].e_fi ? oh(g) : '0);
      chk("tab_ent", ent, tabla[i].e_ent);
      chk("tab_stb", stb, tabla[i].e_stb);
      bal_m = tabla[i].e_bal;
    end
    REQ = 4'b0001;
    TIPO_TRANS = '0;
    MONTO_BUS = '0;
    MONTO_BUS[AM-1:0] = 32'd1;
    tick();
    chk("to_grant", GRANT, 4'b0001);
    tick();
    CARGAR_BALANCE = 1'b1;
    BALANCE_INICIAL = 64'd12345;
    tick();
    CARGAR_BALANCE = 1'b0;
    n = 3;
    while (ACK == '0 && n < 10) begin
      tick();
      n++;
    end
    chk("to_latencia", n, 4);
    chk("to_bal_sin_carga", BALANCE_ACTUALIZADO, bal_m + 64'd1);
    bal_m = bal_m + 64'd1;
    hi = 0;
    while (GRANT != '0 && hi < 40) begin
      hi++;
      tick();
    end
    chk("timeout_ciclos", hi, 16);
    chk("timeout_ocupado", OCUPADO, 0);
    REQ = '0;
    rr_m = 1;
    tick();
    REQ = 4'b0100;
    TIPO_TRANS = 4'b0100;
    MONTO_BUS[2*AM +: AM] = 32'd1;
    tick();
    tick();
    reset = 1'b1;
    REQ = '0;
    tick();
    reset = 1'b0;
    chk_reset_outs("reset_ejecuta");
    ackseen = 1'b0;
    repeat (8) begin
      tick();
      ackseen = ackseen | (|ACK);
    end
    chk("reset_sin_ack", ackseen, 0);
    bal_m = '0;
    rr_m = 0;
    REQ = '1;
    TIPO_TRANS = '0;
    for (int k = 0; k < N; k++) MONTO_BUS[k*AM +: AM] = 32'd1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (GRANT == '0 && n < 40) begin
        tick();
        n++;
      end
`ifdef CAJERO_PRIORIDAD_FIJA_EN
      eg = 0;
`else
      eg = k % N;
`endif
      chk("rr_orden", GRANT, oh(eg));
      n = 0;
      while (GRANT != '0 && n < 40) begin
        tick();
        n++;
      end
    end
    REQ = '0;
    tick();
    chk("rr_bal", BALANCE_ACTUALIZADO, 64'd5);
`ifdef CAJERO_PRIORIDAD_FIJA_EN
    rr_m = 0;
`else
    rr_m = 1;
`endif
    CARGAR_BALANCE = 1'b1;
    BALANCE_INICIAL = 64'd777;
    REQ = 4'b0010;
    TIPO_TRANS = '0;
    MONTO_BUS[AM +: AM] = 32'd3;
    tick();
    chk("prio_carga_stb", BALANCE_STB, 1);
    chk("prio_carga_grant", GRANT, '0);
    chk("prio_carga_bal", BALANCE_ACTUALIZADO, 64'd777);
    chk("prio_carga_ocupado", OCUPADO, 0);
    CARGAR_BALANCE = 1'b0;
    bal_m = 64'd777;
    do_txn(4'b0010, '0, MONTO_BUS, g, fi, ent, stb, b);
    chk("prio_bal", b, 64'd780);
    chk("prio_stb", stb, 1);
    bal_m = 64'd780;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) do_load($urandom_range(0, 1) == 0 ? 64'($urandom_range(0, 5000)) : MAXB - 64'($urandom_range(0, 3000)));
      r = N'($urandom_range(1, (1 << N) - 1));
      t = N'($urandom);
      for (int k = 0; k < N; k++) mb[k*AM +: AM] = $urandom_range(0, 7) == 0 ? $urandom : $urandom_range(0, 3000);
      eg = winner(r);
      m = mb[eg*AM +: AM];
      w = t[eg];
      s = {1'b0, bal_m} + {{(AB-AM+1){1'b0}}, m};
      e_fi = w && (AB'(m) > bal_m);
      e_ent = w && !e_fi;
      nb = w ? (e_fi ? bal_m : bal_m - AB'(m)) : (s > {1'b0, MAXB} ? MAXB : s[AB-1:0]);
      do_txn(r, t, mb, g, fi, ent, stb, b);
      chk("rnd_bal", b, nb);
      chk("rnd_fi", fi, e_fi ? oh(eg) : '0);
      chk("rnd_ent", ent, e_ent);
      chk("rnd_stb", stb, nb != bal_m);
      bal_m = nb;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
